// File: rtl/sram_fifo_reader.sv
// sram_fifo_reader
// ----------------
// Drain-side controller for the SRAM-backed event FIFO. It watches the FIFO
// occupancy, pops words in bursts through the show-ahead read port and
// forwards them to the readout path on a valid/ready stream. Each pop is
// followed by a one-cycle GAP because the SRAM head word needs two cycles
// to refresh. A 2-entry skid buffer decouples downstream backpressure from
// the pop sequencing.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   fifo_empty   FIFO empty flag
//   fifo_numel   FIFO occupancy (CNT_W bits)
//   fifo_rdata   show-ahead head word, valid while fifo_empty=0
//   fifo_rd_en   one-cycle pop strobe to the FIFO
//   flush_i      level: drain whatever is present, ignoring THRESH
//   m_valid, m_ready, m_data, m_last   output stream; m_last ends a burst
//   busy_o       FSM active or output buffer non-empty
//   underrun_o   sticky: FIFO ran dry in the middle of a burst
//
// Optional feature: define SRAM_FIFO_READER_TIMEOUT_EN to build an idle
// timer that forces a partial burst after TIMEOUT cycles of sub-threshold
// occupancy. Without it, partial bursts only drain through flush_i.

module sram_fifo_reader #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 13,
  parameter int THRESH    = 16,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_numel,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  input  logic              flush_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy_o,
  output logic              underrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ZERO_C      = '0;
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   remaining_reg, remaining_next;
  logic               underrun_reg, underrun_next;

  // Output buffer bookkeeping
  logic [1:0]         count_reg;
  logic               wr_ptr_reg, rd_ptr_reg;
  logic               push, push_last, pop, mark_last;
  logic               mark_ptr;
  logic [DATA_W-1:0]  entry_data [2];
  logic               entry_last [2];

  logic               start;
  logic               timeout_hit;
  logic [CNT_W-1:0]   burst_len;

  // ---------------------------------------------------------------------
  // Idle timeout (optional)
  // ---------------------------------------------------------------------
`ifdef SRAM_FIFO_READER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
  logic [TO_W-1:0] timeout_reg;

  // Counts only while sitting in IDLE on a non-empty, sub-threshold FIFO;
  // saturates so a long wait cannot wrap and miss the trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= '0;
    end else if (state_reg != IDLE || state_next != IDLE || fifo_empty) begin
      timeout_reg <= '0;
    end else if (fifo_numel < THRESH_C && timeout_reg < TIMEOUT_C) begin
      timeout_reg <= timeout_reg + TO_W'(1);
    end
  end

  assign timeout_hit = (timeout_reg >= TIMEOUT_C);
`else
  assign timeout_hit = 1'b0;
`endif

  assign start     = (fifo_numel >= THRESH_C) || (flush_i && !fifo_empty) || timeout_hit;
  assign burst_len = (fifo_numel < MAX_BURST_C) ? fifo_numel : MAX_BURST_C;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    underrun_next  = underrun_reg;
    push           = 1'b0;
    push_last      = 1'b0;
    mark_last      = 1'b0;
    fifo_rd_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = POP;
          remaining_next = burst_len;
        end
      end
      POP: begin
        if (remaining_reg == ZERO_C) begin
          // Only reachable if occupancy read as zero at burst start.
          state_next = IDLE;
        end else if (fifo_empty) begin
          // FIFO ran dry: close the burst on the newest buffered word.
          underrun_next  = 1'b1;
          mark_last      = (count_reg != 2'd0);
          remaining_next = ZERO_C;
          state_next     = IDLE;
        end else if (count_reg != 2'd2) begin
          push           = 1'b1;
          push_last      = (remaining_reg == ONE_C);
          fifo_rd_en     = 1'b1;
          remaining_next = remaining_reg - ONE_C;
          state_next     = GAP;
        end
      end
      GAP: begin
        state_next = (remaining_reg == ZERO_C) ? IDLE : POP;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // 2-entry output buffer
  // ---------------------------------------------------------------------
  assign pop      = (count_reg != 2'd0) && m_ready;
  assign mark_ptr = ~wr_ptr_reg;  // slot written most recently

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_W-1:0] data_reg;
      logic              last_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
          last_reg <= 1'b0;
        end else if (push && wr_ptr_reg == 1'(gi)) begin
          data_reg <= fifo_rdata;
          last_reg <= push_last;
        end else if (mark_last && mark_ptr == 1'(gi)) begin
          last_reg <= 1'b1;
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_last[gi] = last_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign m_valid    = (count_reg != 2'd0);
  assign m_data     = entry_data[rd_ptr_reg];
  assign m_last     = entry_last[rd_ptr_reg];
  assign busy_o     = (state_reg != IDLE) || (count_reg != 2'd0);
  assign underrun_o = underrun_reg;

endmodule

// File: tb/tb_sram_fifo_reader.sv
// Directed testbench for sram_fifo_reader. A behavioural show-ahead FIFO
// feeds the DUT; accepted output words and pop strobes are logged each
// cycle and compared against hand-computed expectations.

module tb_sram_fifo_reader;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 13;
  localparam int THRESH    = 16;
  localparam int MAX_BURST = 64;
  localparam int TIMEOUT   = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_numel;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_rd_en;
  logic              flush_i = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy_o;
  logic              underrun_o;

  sram_fifo_reader #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .THRESH(THRESH),
    .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_numel(fifo_numel), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .flush_i(flush_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy_o(busy_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] fq[$];      // FIFO model contents
  logic [DATA_W:0]   outq[$];    // accepted {last, data}
  int                pop_cyc[$]; // cycle numbers of pop strobes
  bit                ovr_en = 1'b0;
  logic [CNT_W-1:0]  ovr_val = '0;
  int                cyc = 0;
  int                checks = 0;
  int                passed = 0;

  logic              s_rd_en, s_valid, s_last, s_busy, s_under;
  logic [DATA_W-1:0] s_data;

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() == 0) ? 32'hDEAD_BEEF : fq[0];
    fifo_numel = ovr_en ? ovr_val : CNT_W'(fq.size());
  endtask

  // One clock: sample at negedge, let the edge pass, update the FIFO model.
  task automatic tick();
    @(negedge clk);
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_busy  = busy_o;
    s_under = underrun_o;
    if (s_valid && m_ready) outq.push_back({s_last, s_data});
    if (s_rd_en) pop_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (s_rd_en && fq.size() > 0) void'(fq.pop_front());
    cyc++;
    drive_fifo();
  endtask

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && outq.size() < n; i++) tick();
    ok = (outq.size() >= n);
  endtask

  task automatic load(input logic [DATA_W-1:0] base, input int n);
    for (int i = 1; i <= n; i++) fq.push_back(base + DATA_W'(i));
    drive_fifo();
  endtask

  task automatic clear_logs();
    outq.delete();
    pop_cyc.delete();
  endtask

  // Counts order errors and last-bit positions for a drained block of words.
  task automatic scan(input logic [DATA_W-1:0] base, input int n,
                      output int errs, output int nlast);
    errs = 0;
    nlast = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= outq.size() || outq[i][DATA_W-1:0] !== base + DATA_W'(i + 1)) errs++;
      if (i < outq.size() && outq[i][DATA_W] === 1'b1) nlast++;
    end
  endtask

  task automatic test_reset();
    clear_logs();
    rst = 1'b1;
    load(32'h100, 100);
    tick();
    checks++;
    if ({s_rd_en, s_valid, s_last, s_busy, s_under} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {s_rd_en, s_valid, s_last, s_busy, s_under});
    else passed++;
    checks++;
    if (s_data !== '0) $display("FAIL reset_m_data: got %h expected 0", s_data);
    else passed++;
    tick();
    checks++;
    if (s_rd_en !== 1'b0) $display("FAIL reset_no_pop: got %b expected 0", s_rd_en);
    else passed++;
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    checks++;
    if (s_rd_en !== 1'b0) $display("FAIL release_idle: got %b expected 0", s_rd_en);
    else passed++;
    tick();
    checks++;
    if (s_rd_en !== 1'b1) $display("FAIL release_start: got %b expected 1", s_rd_en);
    else passed++;
  endtask

  // Continues draining the 100 words loaded during test_reset.
  task automatic test_max_burst();
    bit ok;
    int errs, nlast, n2, n3;
    wait_out(100, 500, ok);
    checks++;
    if (!ok) $display("FAIL split_count: got %0d words expected 100", outq.size());
    else passed++;
    scan(32'h100, 100, errs, nlast);
    checks++;
    if (errs !== 0) $display("FAIL split_order: got %0d errors expected 0", errs);
    else passed++;
    checks++;
    if (nlast !== 2 || outq[63][DATA_W] !== 1'b1 || outq[99][DATA_W] !== 1'b1)
      $display("FAIL split_last: got %0d lasts (w64=%b w100=%b) expected 2 (1,1)", nlast, outq[63][DATA_W], outq[99][DATA_W]);
    else passed++;
    n2 = 0;
    n3 = 0;
    for (int i = 1; i < pop_cyc.size(); i++) begin
      if (pop_cyc[i] - pop_cyc[i-1] == 2) n2++;
      if (pop_cyc[i] - pop_cyc[i-1] == 3) n3++;
    end
    checks++;
    if (n2 !== 98 || n3 !== 1) $display("FAIL split_spacing: got %0d x2 / %0d x3 expected 98 / 1", n2, n3);
    else passed++;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_threshold();
    bit ok;
    int errs, nlast, n2;
    clear_logs();
    load(32'h0, 20);
    wait_out(20, 200, ok);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (!ok || outq.size() != 20) $display("FAIL thresh_count: got %0d words expected 20", outq.size());
    else passed++;
    scan(32'h0, 20, errs, nlast);
    checks++;
    if (errs !== 0) $display("FAIL thresh_order: got %0d errors expected 0", errs);
    else passed++;
    checks++;
    if (nlast !== 1 || outq[19][DATA_W] !== 1'b1) $display("FAIL thresh_last: got %0d lasts expected 1 on word 0x14", nlast);
    else passed++;
    n2 = 0;
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] == 2) n2++;
    checks++;
    if (pop_cyc.size() != 20 || n2 !== 19) $display("FAIL thresh_spacing: got %0d pops / %0d gaps of 2 expected 20 / 19", pop_cyc.size(), n2);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int errs, nlast, unstable, pops4;
    logic [DATA_W-1:0] d0;
    clear_logs();
    m_ready = 1'b1;
    load(32'h200, 20);
    wait_out(5, 100, ok);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    d0 = s_data;
    pops4 = pop_cyc.size();
    unstable = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_data !== d0 || s_valid !== 1'b1 || s_rd_en !== 1'b0) unstable++;
    end
    checks++;
    if (d0 !== 32'h206) $display("FAIL bp_head: got %h expected 00000206", d0);
    else passed++;
    checks++;
    if (unstable !== 0 || pop_cyc.size() != pops4) $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable);
    else passed++;
    checks++;
    if (pop_cyc.size() - outq.size() !== 2) $display("FAIL bp_buffered: got %0d expected 2", pop_cyc.size() - outq.size());
    else passed++;
    m_ready = 1'b1;
    wait_out(20, 200, ok);
    for (int i = 0; i < 5; i++) tick();
    scan(32'h200, 20, errs, nlast);
    checks++;
    if (outq.size() != 20 || errs !== 0) $display("FAIL bp_order: got %0d words %0d errors expected 20 / 0", outq.size(), errs);
    else passed++;
    checks++;
    if (nlast !== 1 || outq[19][DATA_W] !== 1'b1) $display("FAIL bp_last: got %0d lasts expected 1 on 20th", nlast);
    else passed++;
  endtask

  task automatic test_partial();
    bit ok;
    int errs, nlast, c0;
    clear_logs();
    m_ready = 1'b1;
    load(32'h300, 5);
    c0 = cyc;
`ifdef SRAM_FIFO_READER_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) tick();
    checks++;
    if (pop_cyc.size() != 0) $display("FAIL partial_early: got %0d pops expected 0", pop_cyc.size());
    else passed++;
    wait_out(5, 60, ok);
    checks++;
    if (pop_cyc.size() == 0 || pop_cyc[0] - c0 !== TIMEOUT + 1) $display("FAIL partial_timeout: got first pop at %0d expected %0d", pop_cyc.size() ? pop_cyc[0] - c0 : -1, TIMEOUT + 1);
    else passed++;
`else
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (pop_cyc.size() != 0 || s_busy !== 1'b0) $display("FAIL partial_hold: got %0d pops busy=%b expected 0 pops busy=0", pop_cyc.size(), s_busy);
    else passed++;
    flush_i = 1'b1;
    wait_out(5, 60, ok);
    checks++;
    if (c0 + 30 > pop_cyc[0]) $display("FAIL partial_flush: got first pop at %0d expected after %0d", pop_cyc[0], c0 + 30);
    else passed++;
`endif
    for (int i = 0; i < 4; i++) tick();
    flush_i = 1'b0;
    scan(32'h300, 5, errs, nlast);
    checks++;
    if (!ok || outq.size() != 5 || errs !== 0) $display("FAIL partial_order: got %0d words %0d errors expected 5 / 0", outq.size(), errs);
    else passed++;
    checks++;
    if (nlast !== 1 || outq[4][DATA_W] !== 1'b1) $display("FAIL partial_last: got %0d lasts expected 1 on 5th", nlast);
    else passed++;
  endtask

  task automatic test_underrun();
    bit ok;
    clear_logs();
    checks++;
    if (s_under !== 1'b0) $display("FAIL underrun_pre: got %b expected 0", s_under);
    else passed++;
    m_ready = 1'b0;
    ovr_en  = 1'b1;
    ovr_val = CNT_W'(8);
    load(32'hA0, 3);
    flush_i = 1'b1;
    for (int i = 0; i < 20 && pop_cyc.size() < 2; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    flush_i = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (s_under !== 1'b1) $display("FAIL underrun_flag: got %b expected 1", s_under);
    else passed++;
    checks++;
    if (pop_cyc.size() != 3) $display("FAIL underrun_pops: got %0d expected 3", pop_cyc.size());
    else passed++;
    m_ready = 1'b1;
    wait_out(3, 20, ok);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (!ok || outq.size() != 3 || outq[0] !== 33'h0_000000A1 || outq[1] !== 33'h0_000000A2 || outq[2] !== 33'h1_000000A3)
      $display("FAIL underrun_words: got %0d words [%h %h %h] expected [0a1 0a2 1a3]", outq.size(), outq[0], outq[1], outq[2]);
    else passed++;
    checks++;
    if (s_under !== 1'b1 || s_busy !== 1'b0 || pop_cyc.size() != 3)
      $display("FAIL underrun_idle: got under=%b busy=%b pops=%0d expected 1 0 3", s_under, s_busy, pop_cyc.size());
    else passed++;
    ovr_en = 1'b0;
    drive_fifo();
  endtask

  initial begin
    drive_fifo();
    test_reset();
    test_max_burst();
    test_threshold();
    test_backpressure();
    test_partial();
    test_underrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
